pwm_mmio_multi: RTL
===================

// Module: pwm_mmio_multi
//
// PURPOSE
//   Memory-mapped, multi-channel PWM controller. NUM_CH independent channels,
//   each with its own prescaler, period, duty and polarity. Period/duty writes
//   are shadowed and take effect only at the channel's period boundary
//   (glitch-free). Adds a per-channel period-wrap interrupt with mask and
//   W1C status. Sits on the same 32-bit MMIO bus as the other peripherals
//   and drives the pwm_out pins directly.
//
// PARAMETERS
//   NUM_CH   4         number of PWM channels (1..16)
//   CNT_W    16        period/duty counter width in bits (2..32)
//   BASE_HI  16'hBBBB  addr_in[31:16] value that selects this block
//
// PORTS
//   clk             in   1       system clock
//   rst             in   1       synchronous reset, active-high
//   addr_in         in   32      MMIO address
//   data_in         in   32      write data
//   wr_in           in   1       write strobe (one write per cycle)
//   rd_in           in   1       read strobe
//   rd_valid_out    out  1       data_out valid (1 cycle after rd_in)
//   data_out        out  32      read data
//   pwm_out         out  NUM_CH  per-channel PWM outputs (registered)
//   irq_out         out  1       level interrupt: |(IRQ_STATUS & IRQ_MASK)
//
// BEHAVIOUR
//   Reg map (offset = addr_in[15:0]; ch = 0..NUM_CH-1):
//   - ch*16+0x0 CTRL: [0] en, [1] invert, [15:8] prescale; other bits RAZ/WI.
//   - ch*16+0x4 PERIOD shadow; ch*16+0x8 DUTY shadow. Writes keep
//     data_in[CNT_W-1:0]; reads are zero-extended.
//   - 0x1000 IRQ_STATUS (W1C, bit ch); 0x1004 IRQ_MASK (RW, bit ch);
//     0xFFFF free-running 32-bit clk counter (RO, wraps).
//   - Unmapped offsets, or offsets of channels >= NUM_CH: writes ignored,
//     reads return 0.
//   Reset: all registers, counters, status and mask are 0.
//   Reset values: pwm_out=0, irq_out=0, data_out=0, rd_valid_out=0.
//   rst in mid-operation aborts the PWM cycle on the next edge.
//   Read path:
//   - rd_valid_out <= rd_in every cycle, whatever the address.
//   - data_out updates only when rd_in is high with a BASE_HI hit; otherwise
//     it holds. A read with a non-matching addr_in[31:16] still pulses
//     rd_valid_out but leaves data_out unchanged.
//   - Read and write to the same register in the same cycle: the read
//     returns the old value.
//   Channel (en=1):
//   - The prescaler counts 0..prescale, then issues a tick and returns to 0.
//     Result: one tick every prescale+1 clocks.
//   - On each tick, cnt advances 0..per_act. At cnt==per_act it wraps to 0
//     and loads per_act/duty_act from the shadows (boundary event).
//   - Compare: cmp = (cnt < duty_act). pwm_out[ch] <= cmp ^ invert, so
//     pwm_out lags cnt by one cycle.
//   - duty_act=0: constant low. duty_act>per_act: constant high.
//   - per_act=0: cnt stays 0 and every tick is a boundary.
//   Enable/disable:
//   - en 0->1: prescaler and cnt restart at 0, and per_act/duty_act load from
//     the shadows in the same cycle.
//   - en=0: prescaler and cnt held at 0, pwm_out[ch]=0 regardless of invert,
//     no IRQ.
//   - A CTRL write takes effect immediately; invert and prescale are not
//     shadowed.
//   IRQ:
//   - Each boundary event sets IRQ_STATUS[ch] on the next edge.
//   - If a set and a W1C clear hit the same bit in the same cycle, set wins.
//   - irq_out is combinational from the status and mask registers.
//
// TESTING
//   1. rst, then read 0x0, 0x4, 0x1000 and 0xFFFF -> 0, 0, 0, small count.
//      rd_valid_out is high exactly 1 cycle after each rd_in.
//   2. ch0: PERIOD=9, DUTY=3, CTRL=0x1 -> pwm_out[0] high 3 clks, low 7,
//      repeating every 10 clks.
//   3. ch1: prescale=3, PERIOD=4, DUTY=2 -> period 20 clks, high 8.
//      Write DUTY=4 mid-period -> unchanged until the next wrap, then high 16.
//   4. Edge cases: DUTY=0 -> constant 0; DUTY=PERIOD+1 -> constant 1;
//      invert=1 with DUTY=3, PERIOD=9 -> low 3 / high 7; en=0 -> 0.
//   5. IRQ_MASK=0x1 with ch0 running -> irq_out rises 1 clk after the wrap.
//      Write 0x1000 <= 0x1 -> clears. A W1C landing on a wrap cycle leaves
//      status set.
//   6. Assert rst mid-period -> next edge: all outputs 0, counters 0.
//      Address 0xBBBB0040 with NUM_CH=4 -> read 0, writes ignored.

Source files
------------

// File: rtl/pwm_mmio_multi.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pwm_mmio_multi : MMIO multi-channel PWM with shadowed period/duty, per-    |
// |                  channel prescaler/polarity and masked wrap interrupts.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pwm_mmio_multi #(
  parameter int          NUM_CH  = 4,
  parameter int          CNT_W   = 16,
  parameter logic [15:0] BASE_HI = 16'hBBBB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_in,
  input  logic              wr_in,
  input  logic              rd_in,
  output logic              rd_valid_out,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq_out
);

  localparam logic [15:0] c_off_irq_status = 16'h1000;
  localparam logic [15:0] c_off_irq_mask   = 16'h1004;
  localparam logic [15:0] c_off_free_cnt   = 16'hFFFF;
  localparam logic [3:0]  c_reg_ctrl       = 4'h0;
  localparam logic [3:0]  c_reg_period     = 4'h4;
  localparam logic [3:0]  c_reg_duty       = 4'h8;

  logic             r_en       [NUM_CH];
  logic             r_inv      [NUM_CH];
  logic [7:0]       r_pre      [NUM_CH];
  logic [7:0]       r_pre_cnt  [NUM_CH];
  logic [CNT_W-1:0] r_per_sh   [NUM_CH];
  logic [CNT_W-1:0] r_duty_sh  [NUM_CH];
  logic [CNT_W-1:0] r_per_act  [NUM_CH];
  logic [CNT_W-1:0] r_duty_act [NUM_CH];
  logic [CNT_W-1:0] r_cnt      [NUM_CH];

  logic [NUM_CH-1:0] r_pwm;
  logic [NUM_CH-1:0] r_irq_status;
  logic [NUM_CH-1:0] r_irq_mask;
  logic [31:0]       r_free_cnt;
  logic [31:0]       r_rdata;
  logic              r_rd_valid;

  logic              w_hit;
  logic [15:0]       w_off;
  logic              w_wr_hit;
  logic [NUM_CH-1:0] w_wr_sel;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_bnd;
  logic [NUM_CH-1:0] w_w1c;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_hit    = (addr_in[31:16] == BASE_HI);
  assign w_off    = addr_in[15:0];
  assign w_wr_hit = wr_in && w_hit;
  assign w_w1c    = (w_wr_hit && (w_off == c_off_irq_status)) ? data_in[NUM_CH-1:0] : '0;
  assign w_unused = ^data_in;

  always_comb begin
    w_wr_sel = '0;
    w_tick   = '0;
    w_bnd    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_sel[i] = w_wr_hit && (w_off[15:4] == 12'(i));
      w_tick[i]   = r_en[i] && (r_pre_cnt[i] == r_pre[i]);
      // A boundary is the tick that finds the counter at the active period.
      w_bnd[i]    = w_tick[i] && (r_cnt[i] == r_per_act[i]);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_off == c_off_irq_status) begin
      w_rdata[NUM_CH-1:0] = r_irq_status;
    end else if (w_off == c_off_irq_mask) begin
      w_rdata[NUM_CH-1:0] = r_irq_mask;
    end else if (w_off == c_off_free_cnt) begin
      w_rdata = r_free_cnt;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_off[15:4] == 12'(i)) begin
          case (w_off[3:0])
            c_reg_ctrl:   w_rdata = {16'h0, r_pre[i], 6'h0, r_inv[i], r_en[i]};
            c_reg_period: w_rdata[CNT_W-1:0] = r_per_sh[i];
            c_reg_duty:   w_rdata[CNT_W-1:0] = r_duty_sh[i];
            default:      w_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_en[i]       <= 1'b0;
        r_inv[i]      <= 1'b0;
        r_pre[i]      <= '0;
        r_pre_cnt[i]  <= '0;
        r_per_sh[i]   <= '0;
        r_duty_sh[i]  <= '0;
        r_per_act[i]  <= '0;
        r_duty_act[i] <= '0;
        r_cnt[i]      <= '0;
      end
      r_pwm        <= '0;
      r_irq_status <= '0;
      r_irq_mask   <= '0;
      r_free_cnt   <= '0;
      r_rdata      <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_free_cnt <= r_free_cnt + 32'd1;
      r_rd_valid <= rd_in;
      if (rd_in && w_hit) begin
        r_rdata <= w_rdata;
      end
      // Set is ORed in after the clear so a same-cycle wrap wins over W1C.
      r_irq_status <= (r_irq_status & ~w_w1c) | w_bnd;
      if (w_wr_hit && (w_off == c_off_irq_mask)) begin
        r_irq_mask <= data_in[NUM_CH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_sel[i] && (w_off[3:0] == c_reg_ctrl)) begin
          r_en[i]  <= data_in[0];
          r_inv[i] <= data_in[1];
          r_pre[i] <= data_in[15:8];
        end
        if (w_wr_sel[i] && (w_off[3:0] == c_reg_period)) begin
          r_per_sh[i] <= data_in[CNT_W-1:0];
        end
        if (w_wr_sel[i] && (w_off[3:0] == c_reg_duty)) begin
          r_duty_sh[i] <= data_in[CNT_W-1:0];
        end
        // While idle the active set tracks the shadows, so enabling starts
        // the first cycle with the latest programmed period/duty.
        if (!r_en[i]) begin
          r_pre_cnt[i]  <= '0;
          r_cnt[i]      <= '0;
          r_per_act[i]  <= r_per_sh[i];
          r_duty_act[i] <= r_duty_sh[i];
        end else if (w_tick[i]) begin
          r_pre_cnt[i] <= '0;
          if (w_bnd[i]) begin
            r_cnt[i]      <= '0;
            r_per_act[i]  <= r_per_sh[i];
            r_duty_act[i] <= r_duty_sh[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_pre_cnt[i] <= r_pre_cnt[i] + 8'd1;
        end
        r_pwm[i] <= r_en[i] & ((r_cnt[i] < r_duty_act[i]) ^ r_inv[i]);
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign irq_out      = |(r_irq_status & r_irq_mask);
  assign data_out     = r_rdata;
  assign rd_valid_out = r_rd_valid;

endmodule
`default_nettype wire
